// File: rtl/count_step_monitor.sv
// count_step_monitor: watches a 4-bit free-running counter and flags every
// sample that does not equal (previous + 1) mod 16. Each violation is
// classified, timestamped and queued in a small log FIFO that is drained over a
// valid/ready handshake.
module count_step_monitor #(
  parameter int LOG_DEPTH = 4,
  parameter int TS_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count_in,
  input  logic              cnt_rst_in,
  output logic              viol_pulse,
  output logic [1:0]        viol_type,
  output logic [7:0]        viol_count,
  output logic              log_valid,
  output logic [TS_W+5:0]   log_data,
  input  logic              log_ready,
  output logic              log_overflow
);

  localparam int AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_L = (AW + 1)'(LOG_DEPTH);
  localparam logic [AW:0]     OCC_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]   PTR_ONE = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [TS_W-1:0] TS_ONE  = {{(TS_W - 1){1'b0}}, 1'b1};

  typedef enum logic {SYNC, TRACK} state_t;
  typedef enum logic [1:0] {
    V_NONE  = 2'b00,
    V_STALL = 2'b01,
    V_SKIP  = 2'b10,
    V_ZERO  = 2'b11
  } viol_t;

  state_t            state, state_nxt;
  logic [3:0]        prev, prev_nxt, exp_cnt;
  logic              viol;
  viol_t             vtype;
  logic [TS_W-1:0]   ts;

  logic [TS_W+5:0]   mem [LOG_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       occ;
  logic              full, pop, push_ok, drop;

  // Next-state, prev update and violation classification for the sampled value.
  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    viol      = 1'b0;
    vtype     = V_NONE;
    exp_cnt   = prev + 4'd1;
    if (cnt_rst_in) begin
      // Upstream counter is in reset: stop checking, keep prev as it was.
      state_nxt = SYNC;
    end else begin
      unique case (state)
        SYNC: begin
          prev_nxt  = count_in;
          state_nxt = TRACK;
        end
        TRACK: begin
          prev_nxt = count_in;
          if (count_in != exp_cnt) begin
            viol = 1'b1;
            if (count_in == prev)                        vtype = V_STALL;
            else if (count_in == 4'd0 && exp_cnt != 4'd0) vtype = V_ZERO;
            else                                          vtype = V_SKIP;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head leaves on the
  // same edge; otherwise the push is dropped and recorded as overflow.
  always_comb begin
    full    = (occ == DEPTH_L);
    pop     = log_valid && log_ready;
    push_ok = viol && (!full || pop);
    drop    = viol && full && !pop;
  end

  assign log_valid = (occ != '0);
  // Empty FIFO presents zero so the log port is clean after reset.
  assign log_data  = log_valid ? mem[rd_ptr] : '0;

  // Checker state, counters, registered violation flags and FIFO pointers.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SYNC;
      prev         <= 4'd0;
      ts           <= '0;
      viol_pulse   <= 1'b0;
      viol_type    <= 2'b00;
      viol_count   <= 8'd0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occ          <= '0;
      log_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      ts         <= ts + TS_ONE;
      viol_pulse <= viol;
      viol_type  <= vtype;
      if (viol && viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
      if (drop) log_overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (push_ok && !pop)      occ <= occ + OCC_ONE;
      else if (!push_ok && pop) occ <= occ - OCC_ONE;
    end
  end

  // Log storage write: entry carries the timestamp of the sampling edge.
  // NOTE: the storage array has no reset; occupancy and pointers define which
  // entries are meaningful, and the read port masks the empty case.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= {ts, vtype, count_in};
  end

endmodule

// File: tb/tb_count_step_monitor.sv
// Self-checking bench for count_step_monitor: directed vector table, hand
// sequences for the multi-cycle corners and a randomized run against a
// queue-based reference model.
module tb_count_step_monitor;

  localparam int DEPTH = 4;
  localparam int TSW   = 16;
  localparam int DW    = TSW + 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    count_in = 4'd0;
  logic          cnt_rst_in = 1'b0;
  logic          log_ready = 1'b0;
  logic          viol_pulse;
  logic [1:0]    viol_type;
  logic [7:0]    viol_count;
  logic          log_valid;
  logic [DW-1:0] log_data;
  logic          log_overflow;

  always #5 clk = ~clk;

  count_step_monitor #(.LOG_DEPTH(DEPTH), .TS_W(TSW)) dut (
    .clk          (clk),
    .rst          (rst),
    .count_in     (count_in),
    .cnt_rst_in   (cnt_rst_in),
    .viol_pulse   (viol_pulse),
    .viol_type    (viol_type),
    .viol_count   (viol_count),
    .log_valid    (log_valid),
    .log_data     (log_data),
    .log_ready    (log_ready),
    .log_overflow (log_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask

  // Reference model: "synced" flag, last sample, timestamp, a queue as the log.
  bit              m_sync  = 1'b0;
  logic [3:0]      m_prev  = 4'd0;
  logic [TSW-1:0]  m_ts    = '0;
  logic [DW-1:0]   m_q[$];
  int              m_cnt   = 0;
  bit              m_ovf   = 1'b0;
  bit              m_pulse = 1'b0;
  logic [1:0]      m_type  = 2'b00;

  task automatic model_edge();
    bit         pop;
    bit         v;
    logic [1:0] t;
    int         e;
    if (rst) begin
      m_sync = 0; m_prev = 0; m_ts = 0; m_q.delete();
      m_cnt = 0; m_ovf = 0; m_pulse = 0; m_type = 0;
      return;
    end
    pop = (m_q.size() > 0) && log_ready;
    v = 0;
    t = 2'b00;
    if (cnt_rst_in) begin
      m_sync = 0;
    end else if (!m_sync) begin
      m_prev = count_in;
      m_sync = 1;
    end else begin
      e = (int'(m_prev) + 1) % 16;
      if (int'(count_in) != e) begin
        v = 1;
        if (count_in == m_prev)   t = 2'b01;
        else if (count_in == 0)   t = 2'b11;
        else                      t = 2'b10;
      end
      m_prev = count_in;
    end
    if (pop) void'(m_q.pop_front());
    if (v) begin
      if (m_q.size() < DEPTH) m_q.push_back({m_ts, t, count_in});
      else m_ovf = 1;
      if (m_cnt < 255) m_cnt++;
    end
    m_pulse = v;
    m_type  = t;
    m_ts    = m_ts + 1'b1;
  endtask

  task automatic compare_all(input string tag);
    logic [DW-1:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    check({tag, " viol_pulse"},   32'(viol_pulse),   32'(m_pulse));
    check({tag, " viol_type"},    32'(viol_type),    32'(m_type));
    check({tag, " viol_count"},   32'(viol_count),   32'(m_cnt));
    check({tag, " log_valid"},    32'(log_valid),    32'(m_q.size() > 0));
    check({tag, " log_data"},     32'(log_data),     32'(head));
    check({tag, " log_overflow"}, 32'(log_overflow), 32'(m_ovf));
  endtask

  // Apply inputs away from the edge, clock once, then compare 1 time unit later.
  task automatic step(input string tag, input logic cr, input logic [3:0] c, input logic rdy);
    cnt_rst_in = cr;
    count_in   = c;
    log_ready  = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("reset", 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       cr;
    logic [3:0] c;
    logic       exp_pulse;
    logic [1:0] exp_type;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic          seen;
    logic [TSW-1:0] pp_ts;
    logic [DW-1:0] last;
    int            npop;
    logic [3:0]    nc;
    int            r;

    tbl[0]  = '{1'b0, 4'd2,  1'b0, 2'b00};  // establishes prev
    tbl[1]  = '{1'b0, 4'd3,  1'b0, 2'b00};
    tbl[2]  = '{1'b0, 4'd6,  1'b1, 2'b10};  // skip
    tbl[3]  = '{1'b0, 4'd0,  1'b1, 2'b11};  // zero, exp was 7
    tbl[4]  = '{1'b0, 4'd1,  1'b0, 2'b00};
    tbl[5]  = '{1'b1, 4'd9,  1'b0, 2'b00};  // upstream reset wins over mismatch
    tbl[6]  = '{1'b0, 4'd0,  1'b0, 2'b00};  // re-sync sample
    tbl[7]  = '{1'b0, 4'd1,  1'b0, 2'b00};
    tbl[8]  = '{1'b0, 4'd2,  1'b0, 2'b00};
    tbl[9]  = '{1'b0, 4'd7,  1'b1, 2'b10};  // tracking resumed
    tbl[10] = '{1'b0, 4'd7,  1'b1, 2'b01};  // stall
    tbl[11] = '{1'b0, 4'd0,  1'b1, 2'b11};  // zero, exp 8
    tbl[12] = '{1'b0, 4'd15, 1'b1, 2'b10};  // skip, exp 1
    tbl[13] = '{1'b0, 4'd0,  1'b0, 2'b00};  // 15 -> 0 is legal
    tbl[14] = '{1'b0, 4'd1,  1'b0, 2'b00};

    // Reset state
    do_reset();
    check("reset viol_pulse", 32'(viol_pulse), 0);
    check("reset log_valid",  32'(log_valid),  0);

    // Clean run
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step("clean", 1'b0, 4'(k % 16), 1'b1);
      seen = seen | viol_pulse;
    end
    check("clean any_pulse",  32'(seen),       0);
    check("clean viol_count", 32'(viol_count), 0);
    check("clean log_valid",  32'(log_valid),  0);

    // Vector table: skip/zero, upstream reset, wrap
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step("table", tbl[i].cr, tbl[i].c, 1'b1);
      check($sformatf("table[%0d] pulse", i), 32'(viol_pulse), 32'(tbl[i].exp_pulse));
      check($sformatf("table[%0d] type", i),  32'(viol_type),  32'(tbl[i].exp_type));
    end

    // Stall at timestamp 0x0020, then overflow with log_ready held low
    do_reset();
    for (int k = 0; k < 32; k++) step("pre_stall", 1'b0, 4'((k + 6) % 16), 1'b0);
    step("stall", 1'b0, 4'd5, 1'b0);
    check("stall pulse",      32'(viol_pulse), 1);
    check("stall type",       32'(viol_type),  1);
    check("stall log_data",   32'(log_data),   32'({16'h0020, 2'b01, 4'h5}));
    check("stall viol_count", 32'(viol_count), 1);
    for (int k = 0; k < 5; k++) step("ovf_fill", 1'b0, 4'd5, 1'b0);
    check("ovf flag",       32'(log_overflow), 1);
    check("ovf viol_count", 32'(viol_count),   6);
    check("ovf log_valid",  32'(log_valid),    1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain[%0d] data", i), 32'(log_data),
            32'({16'(16'h0020 + i), 2'b01, 4'h5}));
      step("drain", 1'b1, 4'd5, 1'b1);
    end
    check("drain empty", 32'(log_valid), 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    step("pp_sync", 1'b0, 4'd3, 1'b0);
    for (int k = 0; k < 4; k++) step("pp_fill", 1'b0, 4'd3, 1'b0);
    pp_ts = m_ts;
    step("pp_both", 1'b0, 4'd3, 1'b1);
    check("pp overflow",   32'(log_overflow), 0);
    check("pp viol_count", 32'(viol_count),   5);
    npop = 0;
    last = '0;
    for (int cyc = 0; cyc < 10 && log_valid; cyc++) begin
      last = log_data;
      npop++;
      step("pp_drain", 1'b1, 4'd3, 1'b1);
    end
    check("pp entries", 32'(npop), 4);
    check("pp last",    32'(last), 32'({pp_ts, 2'b01, 4'h3}));

    // Reset mid-operation
    do_reset();
    step("mid_sync", 1'b0, 4'd8, 1'b0);
    for (int k = 0; k < 3; k++) step("mid_fill", 1'b0, 4'd8, 1'b0);
    check("mid viol_count", 32'(viol_count), 3);
    do_reset();
    check("mid rst pulse",    32'(viol_pulse),   0);
    check("mid rst count",    32'(viol_count),   0);
    check("mid rst valid",    32'(log_valid),    0);
    check("mid rst data",     32'(log_data),     0);
    check("mid rst overflow", 32'(log_overflow), 0);
    step("mid_first", 1'b0, 4'd12, 1'b0);
    check("mid first no flag", 32'(viol_pulse), 0);
    step("mid_second", 1'b0, 4'd12, 1'b0);
    check("mid second stall", 32'(viol_type), 1);

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 299));
      rst = (r == 0);
      nc  = ($urandom_range(0, 9) < 7) ? count_in + 4'd1 : 4'($urandom_range(0, 15));
      step("rand", (r >= 1 && r < 12), nc,
           ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1));
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
